// File: rtl/sam_rv32i_wb_tracer.sv
// Trace capture behind sam_rv32i: queues {stamp, NPC, WB_OUT} when NPC changes.
// Ports: clk/RN, cap_en, npc_in, wb_in, tr_* read port, level, overflow, drop_cnt, clr_ovf.
module sam_rv32i_wb_tracer #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                       clk,
  input  logic                       RN,
  input  logic                       cap_en,
  input  logic [31:0]                npc_in,
  input  logic [31:0]                wb_in,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [STAMP_W-1:0]         tr_stamp,
  output logic [31:0]                tr_npc,
  output logic [31:0]                tr_wb,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [31:0]        npc;
    logic [31:0]        wb;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_q;
  entry_t             head_nxt;
  entry_t             new_e;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_nxt;
  logic [LW-1:0]      lvl_nxt;
  logic [STAMP_W-1:0] stamp_q;
  logic [31:0]        prev_npc;
  logic               have_prev;
  logic               cap;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  always_comb begin
    cap  = cap_en & (~have_prev | (npc_in != prev_npc));
    full = (level == LW'(DEPTH));
    pop  = tr_valid & tr_ready;
    push = cap & (~full | pop);
    drop = cap & full & ~pop;
    rd_nxt  = rd_ptr + AW'(pop);
    lvl_nxt = level + LW'(push) - LW'(pop);
    new_e.stamp = stamp_q;
    new_e.npc   = npc_in;
    new_e.wb    = wb_in;
    head_nxt = '0;
    // Next head is the fresh capture only when nothing older remains.
    if (lvl_nxt != '0) begin
      if (push && (rd_nxt == wr_ptr))
        head_nxt = new_e;
      else
        head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      tr_valid  <= 1'b0;
      head_q    <= '0;
      stamp_q   <= '0;
      prev_npc  <= '0;
      have_prev <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      stamp_q  <= stamp_q + 1'b1;
      rd_ptr   <= rd_nxt;
      level    <= lvl_nxt;
      tr_valid <= (lvl_nxt != '0);
      head_q   <= head_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (cap_en) begin
        prev_npc  <= npc_in;
        have_prev <= 1'b1;
      end
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign tr_stamp = head_q.stamp;
  assign tr_npc   = head_q.npc;
  assign tr_wb    = head_q.wb;

endmodule

// File: tb/tb_sam_rv32i_wb_tracer.sv
// Directed bench for sam_rv32i_wb_tracer (DEPTH=16, STAMP_W=16).
// Drives after the rising edge and samples 1ns later.
module tb_sam_rv32i_wb_tracer;

  logic        clk = 1'b0;
  logic        RN;
  logic        cap_en;
  logic [31:0] npc_in;
  logic [31:0] wb_in;
  logic        tr_valid;
  logic        tr_ready;
  logic [15:0] tr_stamp;
  logic [31:0] tr_npc;
  logic [31:0] tr_wb;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  sam_rv32i_wb_tracer #(.DEPTH(16), .STAMP_W(16)) dut (
    .clk(clk), .RN(RN), .cap_en(cap_en),
    .npc_in(npc_in), .wb_in(wb_in),
    .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_stamp(tr_stamp), .tr_npc(tr_npc), .tr_wb(tr_wb),
    .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b1; cap_en = 1'b0; tr_ready = 1'b0;
    clr_ovf = 1'b0; npc_in = '0; wb_in = '0;
    repeat (2) step();
    RN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (tr_valid !== 1'b0 || level !== 5'd0) begin
      n_bad++;
      $display("FAIL rst_empty valid=%b level=%0d want 0/0", tr_valid, level);
    end
    n_cmp++;
    if (tr_npc !== 0 || tr_wb !== 0 || tr_stamp !== 0) begin
      n_bad++;
      $display("FAIL rst_head npc=%h wb=%h st=%h want 0", tr_npc, tr_wb, tr_stamp);
    end
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_ovf ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
    end
    cap_en = 1'b1; npc_in = 32'h0; wb_in = 32'h5;
    step();
    n_cmp++;
    if (tr_valid !== 1'b1 || tr_npc !== 32'h0 || tr_wb !== 32'h5 || tr_stamp !== 16'd0) begin
      n_bad++;
      $display("FAIL first_cap v=%b npc=%h wb=%h st=%0d want 1/0/5/0", tr_valid, tr_npc, tr_wb, tr_stamp);
    end
    step();
    n_cmp++;
    if (level !== 5'd1) begin
      n_bad++;
      $display("FAIL no_recap level=%0d want 1", level);
    end
    cap_en = 1'b0;
  endtask

  task automatic test_change();
    logic [31:0] seq [4];
    logic [31:0] got_npc [8];
    logic [15:0] got_st [8];
    logic [31:0] exp_npc [3];
    logic [15:0] exp_st [3];
    int got;
    seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h4; seq[3] = 32'h8;
    exp_npc[0] = 32'h0; exp_npc[1] = 32'h4; exp_npc[2] = 32'h8;
    exp_st[0] = 16'd0; exp_st[1] = 16'd1; exp_st[2] = 16'd3;
    got = 0;
    do_reset();
    tr_ready = 1'b1; cap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      npc_in = (i < 4) ? seq[i] : 32'h8;
      step();
      if (tr_valid && got < 8) begin
        got_npc[got] = tr_npc;
        got_st[got] = tr_stamp;
        got++;
      end
    end
    cap_en = 1'b0; tr_ready = 1'b0;
    n_cmp++;
    if (got != 3) begin
      n_bad++;
      $display("FAIL chg_count got=%0d want 3", got);
    end
    for (int k = 0; k < 3; k++) begin
      if (k < got) begin
        n_cmp++;
        if (got_npc[k] !== exp_npc[k] || got_st[k] !== exp_st[k]) begin
          n_bad++;
          $display("FAIL chg_entry%0d npc=%h st=%0d want %h/%0d", k, got_npc[k], got_st[k], exp_npc[k], exp_st[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      npc_in = 32'(4 * i); wb_in = 32'(i);
      step();
    end
    cap_en = 1'b0;
    n_cmp++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL ovf_state level=%0d ovf=%b drop=%0d want 16/1/4", level, overflow, drop_cnt);
    end
    tr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (tr_valid !== 1'b1 || tr_npc !== 32'(4 * k)) begin
        n_bad++;
        $display("FAIL ovf_drain%0d v=%b npc=%h want 1/%h", k, tr_valid, tr_npc, 32'(4 * k));
      end
      step();
    end
    tr_ready = 1'b0;
    n_cmp++;
    if (tr_valid !== 1'b0 || level !== 5'd0) begin
      n_bad++;
      $display("FAIL ovf_empty v=%b level=%0d want 0/0", tr_valid, level);
    end
  endtask

  task automatic test_full_pop();
    cap_en = 1'b1; tr_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      npc_in = 32'h100 + 32'(4 * i);
      step();
    end
    n_cmp++;
    if (level !== 5'd16) begin
      n_bad++;
      $display("FAIL fp_fill level=%0d want 16", level);
    end
    tr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      npc_in = 32'h200 + 32'(4 * i);
      step();
      n_cmp++;
      if (level !== 5'd16 || drop_cnt !== 16'd4) begin
        n_bad++;
        $display("FAIL fp_cyc%0d level=%0d drop=%0d want 16/4", i, level, drop_cnt);
      end
    end
    cap_en = 1'b0; tr_ready = 1'b0;
    n_cmp++;
    if (tr_npc !== 32'h114) begin
      n_bad++;
      $display("FAIL fp_head npc=%h want 114", tr_npc);
    end
  endtask

  task automatic test_mid_reset();
    tr_ready = 1'b1;
    repeat (9) step();
    tr_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd7 || drop_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL mr_pre level=%0d drop=%0d want 7/4", level, drop_cnt);
    end
    RN = 1'b1; cap_en = 1'b1; tr_ready = 1'b1; npc_in = 32'h999;
    step();
    RN = 1'b0; cap_en = 1'b0; tr_ready = 1'b0;
    n_cmp++;
    if (tr_valid !== 1'b0 || level !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || tr_npc !== 32'h0) begin
      n_bad++;
      $display("FAIL mr_post v=%b level=%0d drop=%0d ovf=%b npc=%h want all 0", tr_valid, level, drop_cnt, overflow, tr_npc);
    end
  endtask

  task automatic test_clr_ovf();
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      npc_in = 32'h300 + 32'(4 * i);
      step();
    end
    n_cmp++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL clr_pre ovf=%b drop=%0d want 1/1", overflow, drop_cnt);
    end
    npc_in = 32'h400; clr_ovf = 1'b1;
    step();
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd1 || level !== 5'd16) begin
      n_bad++;
      $display("FAIL clr_drop ovf=%b drop=%0d level=%0d want 0/1/16", overflow, drop_cnt, level);
    end
    cap_en = 1'b0;
    step();
    clr_ovf = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_only ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pop_npc [16];
    logic [31:0] pop_wb [16];
    logic [31:0] s_npc;
    logic [31:0] s_wb;
    logic [15:0] s_st;
    logic        s_v;
    int          np;
    np = 0;
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      npc_in = 32'h500 + 32'(4 * i); wb_in = 32'h50 + 32'(i);
      step();
    end
    cap_en = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tr_ready = (c % 2 == 1);
      if (tr_valid && tr_ready && np < 16) begin
        pop_npc[np] = tr_npc;
        pop_wb[np] = tr_wb;
        np++;
      end
      s_v = tr_valid; s_npc = tr_npc; s_wb = tr_wb; s_st = tr_stamp;
      step();
      if (!tr_ready && s_v) begin
        n_cmp++;
        if (tr_valid !== 1'b1 || tr_npc !== s_npc || tr_wb !== s_wb || tr_stamp !== s_st) begin
          n_bad++;
          $display("FAIL hold_c%0d npc=%h wb=%h st=%0d want %h/%h/%0d", c, tr_npc, tr_wb, tr_stamp, s_npc, s_wb, s_st);
        end
      end
    end
    tr_ready = 1'b0;
    n_cmp++;
    if (np != 6 || tr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_count pops=%0d v=%b want 6/0", np, tr_valid);
    end
    for (int k = 0; k < 6; k++) begin
      if (k < np) begin
        n_cmp++;
        if (pop_npc[k] !== 32'h500 + 32'(4 * k) || pop_wb[k] !== 32'h50 + 32'(k)) begin
          n_bad++;
          $display("FAIL b2b_pop%0d npc=%h wb=%h want %h/%h", k, pop_npc[k], pop_wb[k], 32'h500 + 32'(4 * k), 32'h50 + 32'(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    test_clr_ovf();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sam_rv32i_wb_tracer.md
Name: sam_rv32i_wb_tracer

Overview:
- Trace-capture stage directly downstream of the sam_rv32i core; consumes the core's NPC and WB_OUT outputs.
- Each cycle on which NPC changes, the block records the tuple {cycle stamp, NPC, WB_OUT} into an internal FIFO.
- A ready/valid read port drains the FIFO to a debug or UART bridge; a sticky flag and a drop counter report overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- STAMP_W, 16, cycle-stamp width; the stamp wraps modulo 2^STAMP_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- RN  in  1  reset; synchronous, active-high.
- cap_en  in  1  capture enable.
- npc_in  in  32  connects to core NPC.
- wb_in  in  32  connects to core WB_OUT.
- tr_valid  out  1  head entry available.
- tr_ready  in  1  consumer accepts the head entry.
- tr_stamp  out  STAMP_W  cycle stamp of the head entry.
- tr_npc  out  32  NPC of the head entry.
- tr_wb  out  32  WB_OUT of the head entry.
- level  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one capture was dropped.
- drop_cnt  out  16  dropped captures; saturates at 0xFFFF.
- clr_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- Reset (RN=1 at a clock edge): all state is cleared.
  - FIFO is emptied; level=0; tr_valid=0.
  - tr_stamp, tr_npc and tr_wb read 0.
  - overflow=0; drop_cnt=0; stamp counter=0; prev_npc=0; have_prev=0.
  - Reset overrides every other input on the same edge, including mid-drain.
- Stamp counter: increments every non-reset cycle regardless of cap_en; wraps at 2^STAMP_W.
- Capture condition (evaluated per cycle): cap_en=1 AND (have_prev=0 OR npc_in != prev_npc).
- prev_npc and have_prev:
  - When cap_en=1, prev_npc<=npc_in and have_prev<=1 on every cycle.
  - When cap_en=0, both hold their values.
  - Consequence: after enable is reasserted, a still-unchanged NPC is not recaptured.
- Captured entry: {current stamp counter value, npc_in, wb_in}, all sampled at that same edge.
- FIFO organisation:
  - Circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally.
  - level tracks occupancy.
  - Head data is registered (show-ahead): an entry written at edge t is visible with tr_valid=1 after edge t if the FIFO was empty. Latency is 1 cycle.
- Pop: occurs when tr_valid && tr_ready at an edge. The next entry appears after that edge, or tr_valid falls if the FIFO empties.
- Data stability: tr_stamp, tr_npc and tr_wb are stable while tr_valid=1 and tr_ready=0.
- Full FIFO (level==DEPTH):
  - Capture without a simultaneous pop: the entry is dropped; overflow<=1; drop_cnt increments, saturating at 0xFFFF.
  - Capture with a simultaneous pop: the push is accepted; level stays at DEPTH; no drop.
- Empty FIFO with a simultaneous capture and tr_ready=1: no pop occurs, because tr_valid was 0; the push is accepted.
- tr_ready while tr_valid=0: ignored.
- clr_ovf:
  - clr_ovf=1 clears overflow and drop_cnt on that edge.
  - If a drop happens on the same edge, clear wins for overflow, and drop_cnt is loaded with 1.
- level arithmetic per edge: +1 on push only; -1 on pop only; unchanged on both or neither.
- No combinational path from tr_ready to tr_valid.

Test Plan:
- Reset then capture: RN=1 for 2 cycles, then cap_en=1 with constant npc_in=0x0000_0000 and wb_in=0x5.
  - Exactly one entry is captured: tr_valid=1 one cycle later with tr_npc=0, tr_wb=5, tr_stamp=0.
- Change detection: npc_in sequence 0x0, 0x4, 0x4, 0x8 with tr_ready=1.
  - Three entries are delivered, with NPC 0x0, 0x4, 0x8 and stamps 0, 1, 3.
- Overflow: DEPTH=16, tr_ready=0, NPC incrementing by 4 for 20 cycles.
  - level=16, overflow=1, drop_cnt=4.
  - Draining yields NPC 0x0..0x3C in order.
- Full with simultaneous pop: FIFO full, tr_ready=1, a new NPC each cycle.
  - level stays at 16 and drop_cnt is unchanged.
- Back-pressure hold: tr_ready toggles 0/1 every cycle.
  - Head outputs are unchanged in every tr_ready=0 cycle; no entry is lost or duplicated.
- Mid-operation reset and overflow clear:
  - RN=1 with level=7: after the next edge, tr_valid=0, level=0, drop_cnt=0.
  - clr_ovf coinciding with a drop: overflow=0, drop_cnt=1.
